stdp_synapse_array: RTL and testbench
=====================================

# stdp_synapse_array

Parametrised array of N plastic synapses feeding one post-synaptic neuron, and the next generation of the single-synapse STDP block. It holds one W-bit weight per synapse, a decaying pre-synaptic trace per synapse, and one shared post-synaptic trace. It applies pair-based potentiation and depression with saturating arithmetic and presents a registered summed activation current to the neuron. Weights are host-programmable through a write port and readable through a combinational read port.

## Interface
- N, 4: number of synapses (≥ 2)
- W, 8: weight width
- TW, 8: trace width
- DECAY_SHIFT, 1: trace decay per learning cycle, trace >> DECAY_SHIFT
- LTP_SHIFT, 4: potentiation step = pre_trace >> LTP_SHIFT
- LTD_SHIFT, 4: depression step = post_trace >> LTD_SHIFT
- INIT_WEIGHT, 128: weight value loaded at reset

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- learn  in  1  enables trace and weight updates
- pre_spike  in  N  per-synapse pre-synaptic spike, one bit per synapse
- post_spike  in  1  post-synaptic neuron spike
- wr_en  in  1  host weight write strobe
- wr_addr  in  clog2(N)  synapse index for the write
- wr_data  in  W  weight value to write
- rd_addr  in  clog2(N)  synapse index for readback
- rd_data  out  W  combinational weight[rd_addr]; reads 0 when rd_addr ≥ N
- activation  out  W+clog2(N)  registered sum of the weights of the synapses that spiked

## Operation
- Reset (reset=0, asynchronous): weight[i]=INIT_WEIGHT, pre_trace[i]=0, post_trace=0, activation=0.
- Activation, every cycle regardless of learn: activation ← Σ weight[i] over i with pre_spike[i]=1. The sum uses pre-update weights. Width W+clog2(N), so it never overflows.
- Traces update only when learn=1:
  - pre_trace[i] ← pre_spike[i] ? 2^TW−1 : pre_trace[i] >> DECAY_SHIFT
  - post_trace ← post_spike ? 2^TW−1 : post_trace >> DECAY_SHIFT
- Weight update, only when learn=1. All terms use the current (pre-update) trace values:
  - ltp = post_spike ? (pre_trace[i] >> LTP_SHIFT) : 0
  - ltd = pre_spike[i] ? (post_trace >> LTD_SHIFT) : 0
  - weight[i] ← clamp(weight[i] + ltp − ltd, 0, 2^W−1)
  - Arithmetic is signed, at least W+2 bits wide, before the clamp.
- Simultaneous pre_spike[i] and post_spike: both terms apply in the same cycle from the old traces. Both traces then reload to max.
- learn=0: all traces and weights hold. Activation and the write port stay live.
- Host write: wr_en=1 with wr_addr<N sets weight[wr_addr] ← wr_data, overriding any learning update to that synapse in the same cycle. Other synapses update normally. wr_addr ≥ N is ignored.
- No state machine beyond the per-cycle update. There are no handshakes: every input is sampled each rising edge.

## Timing
- activation: 1-cycle latency from pre_spike to output.
- Weight/trace update: visible on rd_data and used by the activation sum one cycle after the triggering edge.
- A write at edge t is visible on rd_data after t, and is used by the activation sum computed at edge t+1.
- A trace reaches 0 after at most ceil(TW/DECAY_SHIFT) learning cycles without spikes, then stays 0.
- Reset asserted mid-operation clears all state immediately. The first learning update happens on the first rising edge after reset deasserts.

## Test plan
Parameters for all scenarios: N=4, W=8, TW=8, DECAY_SHIFT=1, LTP_SHIFT=4, LTD_SHIFT=4, INIT_WEIGHT=128.
- Reset: pulse reset low, release, sweep rd_addr 0..3 -> rd_data=128 for every address; activation=0; rd_addr=4..7 not applicable (clog2 width) so check rd_addr range boundary via N=3 build -> rd_addr=3 reads 0.
- Potentiation: learn=1, pre_spike=0001 at edge t, post_spike=1 at edge t+1 -> weight[0]=128+15=143 after t+1; weights 1..3 remain 128.
- Depression: learn=1, post_spike at edge t, pre_spike=0010 at edge t+2 (post_trace=127) -> weight[1]=128−7=121.
- Saturation and write priority: write weight[2]=250 then potentiate -> 255; write weight[3]=3 then depress -> 0; write weight[0]=50 in the same cycle as a potentiation of synapse 0 -> weight[0]=50.
- Activation and freeze: write weights 10,20,30,40 with learn=0, drive pre_spike=1011 with post_spike toggling -> activation=70 one cycle later; traces stay 0 and weights are unchanged.
- Reset mid-operation: with traces nonzero and weights modified, assert reset for less than one cycle asynchronously -> all weights return to 128 and activation=0 immediately; a post_spike on the first edge after release causes no potentiation (traces are 0).

Source files
------------

// File: rtl/stdp_synapse_array.sv
`timescale 1ns/1ps
// N plastic synapses with pair-based STDP (saturating weights) driving one summed activation.
// Activation is registered (1 cycle); weight/trace updates show one cycle later; no handshakes, inputs sampled every edge.
module stdp_synapse_array #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int TW          = 8,
    parameter int DECAY_SHIFT = 1,
    parameter int LTP_SHIFT   = 4,
    parameter int LTD_SHIFT   = 4,
    parameter int INIT_WEIGHT = 128,
    localparam int AW         = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            learn,
    input  logic [N-1:0]    pre_spike,
    input  logic            post_spike,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [W-1:0]    rd_data,
    output logic [W+AW-1:0] activation
);

    localparam int SW = W + AW;
    // Two guard bits above the wider of weight/trace keep add-then-subtract exact before clamping.
    localparam int EW = ((W > TW) ? W : TW) + 2;
    localparam logic signed [EW-1:0] WMAX = {{(EW-W){1'b0}}, {W{1'b1}}};

    logic [W-1:0]           weight       [N];
    logic [TW-1:0]          pre_trace    [N];
    logic [TW-1:0]          post_trace;
    logic [W-1:0]           learn_weight [N];
    logic signed [EW-1:0]   ltp          [N];
    logic signed [EW-1:0]   ltd          [N];
    logic signed [EW-1:0]   wsum         [N];
    logic [SW-1:0]          act_sum;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ltp[i] = '0;
            ltd[i] = '0;
            if (post_spike) begin
                ltp[i] = $signed(EW'(pre_trace[i] >> LTP_SHIFT));
            end
            if (pre_spike[i]) begin
                ltd[i] = $signed(EW'(post_trace >> LTD_SHIFT));
            end
            wsum[i] = $signed(EW'(weight[i])) + ltp[i] - ltd[i];
            if (wsum[i][EW-1]) begin
                learn_weight[i] = '0;
            end else if (wsum[i] > WMAX) begin
                learn_weight[i] = '1;
            end else begin
                learn_weight[i] = wsum[i][W-1:0];
            end
        end
    end

    always_comb begin
        act_sum = '0;
        for (int i = 0; i < N; i++) begin
            if (pre_spike[i]) begin
                act_sum = act_sum + SW'(weight[i]);
            end
        end
    end

    // Addresses at or beyond N match no synapse, so they read back as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = weight[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                weight[i]    <= W'(INIT_WEIGHT);
                pre_trace[i] <= '0;
            end
            post_trace <= '0;
            activation <= '0;
        end else begin
            activation <= act_sum;
            for (int i = 0; i < N; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    weight[i] <= wr_data;
                end else if (learn) begin
                    weight[i] <= learn_weight[i];
                end
                if (learn) begin
                    pre_trace[i] <= pre_spike[i] ? {TW{1'b1}} : (pre_trace[i] >> DECAY_SHIFT);
                end
            end
            if (learn) begin
                post_trace <= post_spike ? {TW{1'b1}} : (post_trace >> DECAY_SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_stdp_synapse_array.sv
`timescale 1ns/1ps
// Directed bench for stdp_synapse_array: integer reference model plus hand-computed checkpoints.
module tb_stdp_synapse_array;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       learn = 1'b0;
    logic [3:0] pre_spike = '0;
    logic       post_spike = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [9:0] activation;

    logic       learn3 = 1'b0;
    logic [2:0] pre3 = '0;
    logic       post3 = 1'b0;
    logic       wr_en3 = 1'b0;
    logic [1:0] wr_addr3 = '0;
    logic [7:0] wr_data3 = '0;
    logic [1:0] rd_addr3 = '0;
    logic [7:0] rd_data3;
    logic [9:0] act3;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    int mw [4];
    int mpre [4];
    int mpost;
    int mact;

    stdp_synapse_array #(.N(4)) dut (
        .clk(clk), .reset(reset), .learn(learn), .pre_spike(pre_spike),
        .post_spike(post_spike), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .activation(activation)
    );

    stdp_synapse_array #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .learn(learn3), .pre_spike(pre3),
        .post_spike(post3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .rd_addr(rd_addr3), .rd_data(rd_data3), .activation(act3)
    );

    initial forever #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mw[i]   = 128;
            mpre[i] = 0;
        end
        mpost = 0;
        mact  = 0;
    endtask

    // One clock edge: drive inputs, predict from the rules, commit the prediction at the edge.
    task automatic cyc(input bit ln, input logic [3:0] pre, input bit post,
                       input bit we = 1'b0, input logic [1:0] wa = 2'd0, input logic [7:0] wd = 8'd0);
        int nw [4];
        int v;
        int nact;
        learn = ln; pre_spike = pre; post_spike = post;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = rd_addr + 2'd1;
        nact = 0;
        for (int i = 0; i < 4; i++) begin
            if (pre[i]) nact += mw[i];
            v = mw[i];
            if (ln) v = v + (post ? mpre[i] / 16 : 0) - (pre[i] ? mpost / 16 : 0);
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            if (we && (int'(wa) == i)) v = int'(wd);
            nw[i] = v;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            mw[i] = nw[i];
            if (ln) mpre[i] = pre[i] ? 255 : mpre[i] / 2;
        end
        if (ln) mpost = post ? 255 : mpost / 2;
        mact = nact;
        #1;
    endtask

    task automatic idle(input int n, input bit ln);
        repeat (n) cyc(ln, 4'b0000, 1'b0);
    endtask

    task automatic chk_w(input string name, input logic [1:0] a, input int exp);
        rd_addr = a;
        #1;
        check(name, 32'(rd_data), exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_activation", 32'(activation), mact);
            check("model_rd_data", 32'(rd_data), mw[rd_addr]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            check("reset_weight", 32'(rd_data), 128);
        end
        check("reset_activation", 32'(activation), 0);
        rd_addr3 = 2'd3;
        #1 check("n3_oob_read", 32'(rd_data3), 0);
        rd_addr3 = 2'd2;
        #1 check("n3_last_read", 32'(rd_data3), 128);
        check("n3_activation", 32'(act3), 0);
        rd_addr = 2'd0;
        chk_en = 1'b1;

        // Potentiation: pre on synapse 0, then post one edge later.
        cyc(1'b1, 4'b0001, 1'b0);
        check("pot_activation", 32'(activation), 128);
        cyc(1'b1, 4'b0000, 1'b1);
        chk_w("pot_w0", 2'd0, 143);
        chk_w("pot_w1", 2'd1, 128);
        chk_w("pot_w3", 2'd3, 128);
        idle(10, 1'b1);

        // Depression: post, one decay, then pre on synapse 1 (post_trace = 127).
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0);
        chk_w("dep_w1", 2'd1, 121);
        idle(10, 1'b1);

        // Saturation high and low, then write priority over learning.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'd250);
        cyc(1'b1, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0000, 1'b1);
        chk_w("sat_high_w2", 2'd2, 255);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'd3);
        cyc(1'b1, 4'b1000, 1'b0);
        chk_w("sat_low_w3", 2'd3, 0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd50);
        chk_w("wr_prio_w0", 2'd0, 50);
        chk_w("wr_prio_w3_learns", 2'd3, 7);
        idle(10, 1'b1);

        // Activation with learning frozen.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'd10);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'd20);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'd30);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'd40);
        cyc(1'b0, 4'b1011, 1'b1);
        check("freeze_activation", 32'(activation), 70);
        cyc(1'b0, 4'b1011, 1'b0);
        cyc(1'b0, 4'b1011, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0);
        chk_w("freeze_w1", 2'd1, 20);
        cyc(1'b1, 4'b0000, 1'b1);
        chk_w("freeze_trace_w0", 2'd0, 10);
        chk_w("freeze_trace_w2", 2'd2, 30);

        // Short asynchronous reset while traces and weights are live.
        cyc(1'b1, 4'b0001, 1'b0);
        check("pre_reset_activation", 32'(activation), 10);
        #1 reset = 1'b0;
        model_reset();
        #1 check("mid_reset_activation", 32'(activation), 0);
        chk_w("mid_reset_w0", 2'd0, 128);
        chk_w("mid_reset_w1", 2'd1, 128);
        #1 reset = 1'b1;
        cyc(1'b1, 4'b0000, 1'b1);
        chk_w("post_reset_no_ltp_w0", 2'd0, 128);
        idle(3, 1'b1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
